// File: rtl/uart_pkg.sv
// Shared constants and types for the UART blocks.
// Divisor convention: one bit time lasts cycle+1 clocks.
package uart_pkg;

    localparam int CYCLE_W   = 20;
    localparam int DATA_BITS = 8;
    localparam int BIT_CNT_W = $clog2(DATA_BITS);
    localparam int MIN_CYCLE = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input.
// RST_VAL sets the value both flops take during reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, runtime baud divisor (bit time = cycle+1 clocks).
// Received bytes leave on a valid/ready handshake; framing and overrun are one-clock pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FRE   = 50,
    parameter int BAUD_RATE = 115200
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CYCLE_W-1:0] cycle,
    input  logic               rx_pin,
    output logic [7:0]         rx_data,
    output logic               rx_data_valid,
    input  logic               rx_data_ready,
    output logic               frame_err,
    output logic               overrun
);

    // Out-of-range divisors fall back to the nominal baud rate for this clock
    localparam int                 DEFAULT_CYCLE_INT = CLK_FRE * 1000000 / BAUD_RATE - 1;
    localparam logic [CYCLE_W-1:0] DEFAULT_CYCLE     = CYCLE_W'(DEFAULT_CYCLE_INT);

    logic                 rx_s;
    logic [CYCLE_W-1:0]   cycle_eff;
    logic                 sample;
    logic                 sample_bit;
    logic                 good_stop;

    rx_state_t            state_q;
    rx_state_t            state_d;
    logic [CYCLE_W-1:0]   cnt_q;
    logic [CYCLE_W-1:0]   cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q;
    logic [BIT_CNT_W-1:0] bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q;
    logic [DATA_BITS-1:0] shreg_d;
    logic [7:0]           data_q;
    logic [7:0]           data_d;
    logic                 valid_q;
    logic                 valid_d;
    logic                 frame_err_q;
    logic                 frame_err_d;
    logic                 overrun_q;
    logic                 overrun_d;

    uart_sync2 #(
        .RST_VAL(1'b1)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx_pin),
        .q    (rx_s)
    );

    assign cycle_eff = (cycle < CYCLE_W'(MIN_CYCLE)) ? DEFAULT_CYCLE : cycle;
    assign sample    = (cnt_q == '0);

    always_comb begin
        state_d     = state_q;
        cnt_d       = (cnt_q != '0) ? cnt_q - CYCLE_W'(1) : '0;
        bit_cnt_d   = bit_cnt_q;
        sample_bit  = 1'b0;
        good_stop   = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    cnt_d   = cycle_eff >> 1;
                end
            end
            START: begin
                if (sample) begin
                    cnt_d     = cycle_eff;
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (sample) begin
                    sample_bit = 1'b1;
                    cnt_d      = cycle_eff;
                    if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (sample) begin
                    cnt_d = cycle_eff;
                    if (rx_s) begin
                        good_stop = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = BREAK;
                    end
                end
            end
            BREAK: begin
                // A held-low line must return high before a new start bit counts
                if (rx_s) begin
                    cnt_d   = cycle_eff;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shreg
        assign shreg_d[gi] = (sample_bit && (bit_cnt_q == BIT_CNT_W'(gi))) ? rx_s : shreg_q[gi];
    end

    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (valid_q && rx_data_ready) begin
            valid_d = 1'b0;
        end
        // A byte landing in the same clock as a transfer replaces the outgoing one
        if (good_stop) begin
            if (!valid_q || rx_data_ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_data_valid = valid_q;
    assign frame_err     = frame_err_q;
    assign overrun       = overrun_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver, 8N1 format, LSB first, with a runtime-programmable baud divisor.
- Mates with the team's existing UART transmitter and uses the same `cycle` divisor convention: one bit time = cycle+1 clocks.
- Sits between the external serial RX pin and the byte-oriented host/debug logic.
- Delivers each received byte over a valid/ready handshake and flags framing and overrun errors.

Parameters:
- CLK_FRE, 50, clock frequency in MHz. Informational; used only for the recommended `cycle` value.
- BAUD_RATE, 115200, nominal baud rate. Informational; the recommended `cycle` is CLK_FRE*1e6/BAUD_RATE-1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cycle  in  20  bit period minus 1, in clocks. Legal range 3..2^20-1.
- rx_pin  in  1  asynchronous serial input; idles high.
- rx_data  out  8  received byte.
- rx_data_valid  out  1  rx_data holds an unconsumed byte.
- rx_data_ready  in  1  consumer accepts the byte.
- frame_err  out  1  one-clock pulse: stop bit sampled low.
- overrun  out  1  one-clock pulse: byte lost because the previous byte was not yet consumed.

Behaviour:
- Reset (asynchronous, active-low) sets:
  - state IDLE;
  - synchroniser flops to 1;
  - rx_data 0x00;
  - rx_data_valid, frame_err, overrun all 0;
  - bit counter 0;
  - cycle counter 0.
- Reset asserted mid-frame abandons the frame; no output pulses are generated.
- rx_pin passes through a 2-flop synchroniser; rx_s is the second flop. All decisions use rx_s.
- Cycle counter behaviour:
  - 20-bit down-counter.
  - Reloaded on every state change and on every bit sample in DATA; otherwise decrements.
  - A sample event is counter==0.
  - `cycle` is read only at reload, so a change mid-frame takes effect at the next reload.
- States and transitions:
  - IDLE: if rx_s==0, go to START and load the counter with cycle>>1 (half a bit).
  - START: at the sample event, if rx_s==0 go to DATA and load the counter with cycle; if rx_s==1, treat it as a glitch and return to IDLE with no flag.
  - DATA:
    - At each sample event, shift rx_s into shreg[bit_cnt] and increment bit_cnt.
    - After bit_cnt==7 is sampled, go to STOP and load the counter with cycle.
    - Samples land near mid-bit (half-bit offset ±1 clock).
  - STOP:
    - At the sample event, if rx_s==1 the byte is good; go to IDLE.
    - If rx_s==0, pulse frame_err for one clock, discard the byte, and go to BREAK.
  - BREAK: wait until rx_s==1, then go to IDLE. This prevents a held-low line (break condition) from being re-detected as start bits.
  - Illegal encoding: go to IDLE.
- Byte delivery:
  - On a good stop sample: if rx_data_valid==0 or rx_data_ready==1 in that same cycle, load rx_data=shreg and set rx_data_valid=1 on the next clock. Latency is 1 clk after the stop sample.
  - Otherwise pulse overrun for one clock. The old rx_data and rx_data_valid=1 are kept and the new byte is dropped.
- Handshake:
  - Transfer occurs when rx_data_valid && rx_data_ready on a rising edge.
  - rx_data_valid clears the next clock unless a new byte loads in that same clock, in which case valid stays 1 with the new data.
  - rx_data is stable while rx_data_valid==1 and not yet accepted.
- Back-to-back frames: the receiver reaches IDLE at mid stop bit, so the next start edge is caught with no lost frame.
- End-to-end: frame_err and overrun never assert in the same clock; a byte appears about 9.5 bit times after the start edge.

Decomposition:
- Shared package uart_pkg holds:
  - CYCLE_W=20;
  - the rx state enum: IDLE, START, DATA, STOP, BREAK;
  - the DATA_BITS=8 constant.
- One natural sub-module: uart_sync2, a 2-flop synchroniser with a reset value parameter (RST_VAL=1). It is reusable by other async inputs.

Test Plan:
- Single byte: cycle=7; drive frame 0xA5 (start, 1,0,1,0,0,1,0,1, stop) with ready=1. Required: rx_data=0xA5, valid high for exactly 1 clk, no error flags.
- Back-to-back with backpressure: cycle=15; send 0x00, 0xFF, 0x55 with no idle gap; hold ready=0 until each valid, then pulse it. Required: three bytes received in order, no overrun.
- Overrun: cycle=7; send 0x12 then 0x34 with ready held 0 throughout. Required: overrun pulses 1 clk at the second stop sample; rx_data stays 0x12. Then raise ready: 0x12 is transferred and valid drops.
- Framing error / break: drive start plus 0x3C with a low stop bit, then hold the line low for 30 bit times, then release. Required: one frame_err pulse, no valid, no further frames during the low period. Next frame 0x81 is received correctly.
- Glitch and reset:
  - A 2-clk low pulse on an idle line (cycle=15) must produce no valid and return to IDLE.
  - Asserting rst_n=0 mid-DATA must clear all outputs immediately. After release, a frame 0x6E is received correctly.
